// File: rtl/bits_stream_arbiter_if.sv
// Stream bundle for the bit-stream arbiter: N one-bit requesters
// on the s_axis side, one granted stream on the m_axis side.
interface bits_stream_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] s_axis_tdata;
  logic [NUM_REQ-1:0] s_axis_tvalid;
  logic [NUM_REQ-1:0] s_axis_tready;
  logic               m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
  logic [IW-1:0]      m_axis_tid;

  // master: the arbiter, which drives the merged m_axis stream
  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  m_axis_tready,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    output m_axis_tid
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    output m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  m_axis_tid
  );
endinterface

// File: rtl/bits_stream_arbiter.sv
// Round-robin arbiter: grants one 1-bit requester for BITS_PER_GRANT
// beats, aborting the grant if the owner stalls for TIMEOUT_CYCLES.
module bits_stream_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BITS_PER_GRANT = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  bits_stream_arbiter_if.master axis,
  output logic                  err_timeout,
  output logic [15:0]           grant_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BITS_PER_GRANT + 1);
  localparam int SW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BITS_PER_GRANT - 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [15:0]   gcnt_q, gcnt_d;
  logic          err_q, err_d;

  logic          busy;
  logic          any_vld;
  logic          fire;
  logic          stalled;
  logic          tlast;
  logic [IW-1:0] pick;
  logic [IW-1:0] ix;
  logic          found;

  assign busy    = (state_q == BUSY);
  assign any_vld = |axis.s_axis_tvalid;
  assign tlast   = busy && (beat_q == LAST_BEAT);
  assign fire    = axis.m_axis_tvalid && axis.m_axis_tready;
  assign stalled = busy && !axis.s_axis_tvalid[grant_q];

  assign axis.m_axis_tvalid = busy && axis.s_axis_tvalid[grant_q];
  assign axis.m_axis_tdata  = busy && axis.s_axis_tdata[grant_q];
  assign axis.m_axis_tid    = busy ? grant_q : '0;
  assign axis.m_axis_tlast  = tlast;
  assign axis.s_axis_tready = busy ?
    (NUM_REQ'(axis.m_axis_tready) << grant_q) : '0;

  assign err_timeout = err_q;
  assign grant_count = gcnt_q;

  // search starts one past the previous owner
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    ix    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      ix = IW'((int'(last_q) + i) % NUM_REQ);
      if (!found && axis.s_axis_tvalid[ix]) begin
        found = 1'b1;
        pick  = ix;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    gcnt_d  = gcnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d = BUSY;
          grant_d = pick;
          beat_d  = '0;
          stall_d = '0;
        end
      end
      BUSY: begin
        if (fire) begin
          stall_d = '0;
          if (tlast) begin
            state_d = IDLE;
            last_d  = grant_q;
            beat_d  = '0;
            gcnt_d  = gcnt_q + 16'd1;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (TO_EN && stalled) begin
          if (stall_q == STALL_LIM) begin
            state_d = IDLE;
            last_d  = grant_q;
            beat_d  = '0;
            stall_d = '0;
            err_d   = 1'b1;
          end else begin
            stall_d = stall_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
      stall_q <= '0;
      gcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      gcnt_q  <= gcnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/bits_stream_arbiter.md
BITS_STREAM_ARBITER -- requirements
Module: bits_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of 1-bit stream requesters, legal range 2..8.
REQ-002 SHALL have parameter BITS_PER_GRANT, default 8: beats transferred per grant (one byte for the downstream bits-to-byte streamer), legal range 1..256.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: stall cycles tolerated mid-grant; 0 disables the timeout.
REQ-004 SHALL have port ACLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port s_axis_tdata, input, NUM_REQ bits: bit i is the data bit of requester i.
REQ-007 SHALL have port s_axis_tvalid, input, NUM_REQ bits: per-requester valid.
REQ-008 SHALL have port s_axis_tready, output, NUM_REQ bits: per-requester ready.
REQ-009 SHALL have port m_axis_tdata, output, 1 bit: arbitrated bit to the streamer.
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit: output valid.
REQ-011 SHALL have port m_axis_tready, input, 1 bit: streamer ready.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit: marks the final beat of a grant.
REQ-013 SHALL have port m_axis_tid, output, clog2(NUM_REQ) bits: index of the granted requester.
REQ-014 SHALL have port err_timeout, output, 1 bit: one-cycle pulse on grant abort.
REQ-015 SHALL have port grant_count, output, 16 bits: completed grants since reset.

Function
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 In IDLE with any s_axis_tvalid high, SHALL select a requester round-robin, starting at (last_grant+1) mod NUM_REQ, and enter BUSY on the next edge (1-cycle arbitration latency).
REQ-018 In IDLE with no s_axis_tvalid high, SHALL remain in IDLE with all outputs idle.
REQ-019 In BUSY, m_axis_tdata, m_axis_tvalid, m_axis_tid SHALL be combinational from the granted requester; m_axis_tvalid = s_axis_tvalid[g].
REQ-020 In BUSY, s_axis_tready[g] SHALL equal m_axis_tready; all other s_axis_tready bits SHALL be 0; in IDLE all SHALL be 0.
REQ-021 A beat SHALL be counted only when m_axis_tvalid and m_axis_tready are both high; beat counter width clog2(BITS_PER_GRANT+1).
REQ-022 m_axis_tlast SHALL be high exactly when the beat counter equals BITS_PER_GRANT-1 in BUSY.
REQ-023 On the beat with m_axis_tlast, SHALL return to IDLE, record last_grant = g, increment grant_count (wrapping 0xFFFF -> 0x0000).
REQ-024 The grant SHALL NOT be preempted by other requesters before BITS_PER_GRANT beats or timeout.
REQ-025 Stall counter SHALL increment each BUSY cycle with s_axis_tvalid[g] low and clear on any accepted beat; downstream backpressure (m_axis_tready low) SHALL NOT count.
REQ-026 When the stall counter reaches TIMEOUT_CYCLES (nonzero), SHALL pulse err_timeout for one cycle, return to IDLE, set last_grant = g, and leave grant_count unchanged.
REQ-027 Partial beats already delivered on abort SHALL NOT be retracted; no padding SHALL be inserted.
REQ-028 Requesters dropping tvalid while not granted SHALL have no effect.
REQ-029 A requester deasserting tvalid mid-grant SHALL only stall the grant (see REQ-025).

Reset
REQ-030 While ARESET high at a clock edge: state IDLE, beat and stall counters 0, last_grant = NUM_REQ-1 (so requester 0 has first priority), grant_count 0, err_timeout 0.
REQ-031 Outputs during and after reset until first grant: s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, m_axis_tid 0.
REQ-032 Reset asserted mid-grant SHALL abort immediately without err_timeout pulse; partial beats are discarded from the arbiter's view.

Verification
REQ-033 Single requester 0 streams 0xA5 bits LSB-first, m_axis_tready held 1 -> 8 beats, m_axis_tid 0, m_axis_tlast on 8th beat, grant_count 1.
REQ-034 All 4 requesters valid continuously, 4 grants -> tid order 0,1,2,3 then 0; no interleaving within any 8-beat grant; grant_count 4 after 32 beats.
REQ-035 m_axis_tready toggled 1/0 each cycle during a grant -> 8 beats over about 16 cycles, no err_timeout, no bit loss or duplication.
REQ-036 Requester 2 granted, stops valid after 3 beats, TIMEOUT_CYCLES=255 -> err_timeout pulse 255 cycles after last beat; next grant goes to requester 3; grant_count unchanged.
REQ-037 ARESET pulsed for one cycle after beat 5 of a grant -> next cycle all s_axis_tready 0, grant_count 0; next grant goes to requester 0.
REQ-038 BITS_PER_GRANT=1, requesters 1 and 3 valid -> alternating tid 1,3,1,3 with m_axis_tlast on every beat.
